// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_scheduler
// Description : Per-frame scan of the object table; circle-vs-box test of the
//               ball against every slot, producing flip flags and a corrected
//               ball position. Optional hit statistics via COLLIDE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scheduler #(
    parameter int MAX_OBJS = 64,
    parameter int IDX_W    = 6,
    parameter int BALL_IDX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      ball_x,
    input  logic [15:0]      ball_y,
    input  logic [15:0]      ball_w,
    input  logic [15:0]      ball_h,
    input  logic             vel_x_neg,
    input  logic             vel_y_neg,
    output logic             obj_rd_req,
    output logic [IDX_W-1:0] obj_rd_idx,
    input  logic             obj_rd_ack,
    input  logic [15:0]      obj_x,
    input  logic [15:0]      obj_y,
    input  logic [15:0]      obj_w,
    input  logic [15:0]      obj_h,
    output logic             busy,
    output logic             done,
    output logic             flip_x,
    output logic             flip_y,
    output logic [15:0]      new_ball_x,
    output logic [15:0]      new_ball_y,
    output logic [IDX_W:0]   hit_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EVAL   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_lastSlot = IDX_W'(MAX_OBJS - 1);
    localparam logic [IDX_W-1:0] c_ballSlot = IDX_W'(BALL_IDX);

    state_t           r_state;
    logic [15:0]      r_ballX, r_ballY, r_ballW, r_ballH;
    logic             r_velXNeg, r_velYNeg;
    logic [15:0]      r_objX, r_objY, r_objW, r_objH;
    logic [IDX_W-1:0] r_slot;

    logic signed [16:0] w_r, w_cx, w_cy, w_xLo, w_xHi, w_yLo, w_yHi;
    logic signed [16:0] w_nearX, w_nearY, w_dx, w_dy;
    logic [16:0]        w_adx, w_ady;
    logic [34:0]        w_distSq, w_rSq;
    logic               w_hit, w_xHit, w_yHit, w_advance;
    logic [15:0]        w_hitX, w_hitY;
    logic [IDX_W-1:0]   w_nextSlot;

    // Nearest point of the box to the ball centre; hit when strictly inside radius.
    always_comb begin
        w_r      = $signed({2'b00, r_ballW[15:1]});
        w_cx     = $signed({r_ballX[15], r_ballX}) + w_r;
        w_cy     = $signed({r_ballY[15], r_ballY}) + w_r;
        w_xLo    = $signed({r_objX[15], r_objX});
        w_xHi    = w_xLo + $signed({1'b0, r_objW});
        w_yLo    = $signed({r_objY[15], r_objY});
        w_yHi    = w_yLo + $signed({1'b0, r_objH});
        w_nearX  = (w_cx < w_xLo) ? w_xLo : ((w_cx > w_xHi) ? w_xHi : w_cx);
        w_nearY  = (w_cy < w_yLo) ? w_yLo : ((w_cy > w_yHi) ? w_yHi : w_cy);
        w_dx     = w_nearX - w_cx;
        w_dy     = w_nearY - w_cy;
        w_adx    = w_dx[16] ? $unsigned(-w_dx) : $unsigned(w_dx);
        w_ady    = w_dy[16] ? $unsigned(-w_dy) : $unsigned(w_dy);
        w_distSq = 35'(w_adx) * 35'(w_adx) + 35'(w_ady) * 35'(w_ady);
        w_rSq    = 35'($unsigned(w_r)) * 35'($unsigned(w_r));
        w_hit    = (r_objW != 16'd0) && (w_distSq < w_rSq);
        w_xHit   = w_hit && (w_adx >= w_ady);
        w_yHit   = w_hit && (w_adx <= w_ady);
        w_hitX   = r_velXNeg ? (r_objX + r_objW) : (r_objX - r_ballW);
        w_hitY   = r_velYNeg ? (r_objY + r_objH) : (r_objY - r_ballH);
        w_nextSlot = r_slot + IDX_W'(1);
        w_advance  = (r_state == EVAL) || ((r_state == FETCH) && (r_slot == c_ballSlot));
    end

`ifdef COLLIDE_STATS_EN
    localparam logic [IDX_W:0] c_hitMax = {(IDX_W+1){1'b1}};
`else
    assign hit_count = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            obj_rd_req <= 1'b0;
            obj_rd_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flip_x     <= 1'b0;
            flip_y     <= 1'b0;
            new_ball_x <= '0;
            new_ball_y <= '0;
            r_ballX    <= '0;
            r_ballY    <= '0;
            r_ballW    <= '0;
            r_ballH    <= '0;
            r_velXNeg  <= 1'b0;
            r_velYNeg  <= 1'b0;
            r_objX     <= '0;
            r_objY     <= '0;
            r_objW     <= '0;
            r_objH     <= '0;
            r_slot     <= '0;
`ifdef COLLIDE_STATS_EN
            hit_count  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_ballX    <= ball_x;
                        r_ballY    <= ball_y;
                        r_ballW    <= ball_w;
                        r_ballH    <= ball_h;
                        r_velXNeg  <= vel_x_neg;
                        r_velYNeg  <= vel_y_neg;
                        flip_x     <= 1'b0;
                        flip_y     <= 1'b0;
                        new_ball_x <= ball_x;
                        new_ball_y <= ball_y;
                        r_slot     <= '0;
                        obj_rd_idx <= '0;
                        obj_rd_req <= (c_ballSlot != '0);
                        busy       <= 1'b1;
                        r_state    <= FETCH;
`ifdef COLLIDE_STATS_EN
                        hit_count  <= '0;
`endif
                    end
                end
                FETCH: begin
                    if ((r_slot != c_ballSlot) && obj_rd_ack) begin
                        r_objX     <= obj_x;
                        r_objY     <= obj_y;
                        r_objW     <= obj_w;
                        r_objH     <= obj_h;
                        obj_rd_req <= 1'b0;
                        r_state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (w_xHit) begin
                        flip_x     <= 1'b1;
                        new_ball_x <= w_hitX;
                    end
                    if (w_yHit) begin
                        flip_y     <= 1'b1;
                        new_ball_y <= w_hitY;
                    end
`ifdef COLLIDE_STATS_EN
                    if (w_hit && (hit_count != c_hitMax))
                        hit_count <= hit_count + 1'b1;
`endif
                end
                FINISH: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Shared slot step for both the evaluated and the skipped (ball) slot.
            if (w_advance) begin
                if (r_slot == c_lastSlot) begin
                    obj_rd_req <= 1'b0;
                    done       <= 1'b1;
                    r_state    <= FINISH;
                end else begin
                    r_slot     <= w_nextSlot;
                    obj_rd_idx <= w_nextSlot;
                    obj_rd_req <= (w_nextSlot != c_ballSlot);
                    r_state    <= FETCH;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scheduler
// Description : Scoreboard bench for collision_scheduler with a zero-wait
//               object-table responder and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scheduler;

    localparam int MAX_OBJS = 64;
    localparam int IDX_W    = 6;
    localparam int BALL_IDX = 1;
    localparam int LATENCY  = (MAX_OBJS - 1) * 2 + 2;
`ifdef COLLIDE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      ball_x, ball_y, ball_w, ball_h;
    logic             vel_x_neg, vel_y_neg;
    logic             obj_rd_req;
    logic [IDX_W-1:0] obj_rd_idx;
    logic             obj_rd_ack;
    logic [15:0]      obj_x, obj_y, obj_w, obj_h;
    logic             busy, done, flip_x, flip_y;
    logic [15:0]      new_ball_x, new_ball_y;
    logic [IDX_W:0]   hit_count;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
    } obj_t;

    typedef struct {
        logic        fx;
        logic        fy;
        logic [15:0] nx;
        logic [15:0] ny;
        int          hc;
        int          startCyc;
    } exp_t;

    obj_t tbl [MAX_OBJS];
    exp_t sbQ [$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    logic stall    = 1'b0;
    int   stallIdx = 0;
    logic forceAck = 1'b0;
    logic ballReq  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign obj_rd_ack = (obj_rd_req && !(stall && (int'(obj_rd_idx) == stallIdx))) || forceAck;
    assign obj_x = tbl[obj_rd_idx].x;
    assign obj_y = tbl[obj_rd_idx].y;
    assign obj_w = tbl[obj_rd_idx].w;
    assign obj_h = tbl[obj_rd_idx].h;

    collision_scheduler #(
        .MAX_OBJS (MAX_OBJS),
        .IDX_W    (IDX_W),
        .BALL_IDX (BALL_IDX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_w     (ball_w),
        .ball_h     (ball_h),
        .vel_x_neg  (vel_x_neg),
        .vel_y_neg  (vel_y_neg),
        .obj_rd_req (obj_rd_req),
        .obj_rd_idx (obj_rd_idx),
        .obj_rd_ack (obj_rd_ack),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .busy       (busy),
        .done       (done),
        .flip_x     (flip_x),
        .flip_y     (flip_y),
        .new_ball_x (new_ball_x),
        .new_ball_y (new_ball_y),
        .hit_count  (hit_count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic fx, input logic fy, input int nx, input int ny,
                                   input int hc);
        exp_t e;
        e.fx = fx;
        e.fy = fy;
        e.nx = 16'(nx);
        e.ny = 16'(ny);
        e.hc = hc;
        e.startCyc = 0;
        return e;
    endfunction

    task automatic clearTable();
        for (int i = 0; i < MAX_OBJS; i++) tbl[i] = '0;
    endtask

    task automatic setObj(input int idx, input int x, input int y, input int w, input int h);
        tbl[idx] = {16'(x), 16'(y), 16'(w), 16'(h)};
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (obj_rd_req && (int'(obj_rd_idx) == BALL_IDX)) ballReq = 1'b1;
        if (rst && done) begin
            if (sbQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sbQ.pop_front();
                check("flip_x", flip_x, e.fx);
                check("flip_y", flip_y, e.fy);
                check("new_ball_x", new_ball_x, e.nx);
                check("new_ball_y", new_ball_y, e.ny);
                check("hit_count", hit_count, e.hc);
                check("latency", cycle - e.startCyc + 1, LATENCY);
            end
        end
    end

    task automatic runScan(input int bx, input int by, input logic vx, input logic vy,
                           input exp_t e, input bit midStart);
        @(negedge clk);
        ball_x = 16'(bx); ball_y = 16'(by); ball_w = 16'd8; ball_h = 16'd8;
        vel_x_neg = vx; vel_y_neg = vy;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.startCyc = cycle;
        sbQ.push_back(e);
        check("busy_after_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
        if (midStart) begin
            repeat (20) @(negedge clk);
            ball_x = 16'd0; ball_y = 16'd0; vel_x_neg = 1'b1; vel_y_neg = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            check("scan_timeout", 1, 0);
            sbQ.delete();
        end
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        ball_x = '0; ball_y = '0; ball_w = '0; ball_h = '0;
        vel_x_neg = 1'b0; vel_y_neg = 1'b0;
        clearTable();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", obj_rd_req, 0);
        check("rst_newx", new_ball_x, 0);
        check("rst_hc", hit_count, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // x-hit with +x velocity
        clearTable(); setObj(3, 107, 100, 20, 20);
        runScan(100, 100, 1'b0, 1'b0, mkExp(1, 0, 99, 100, STATS), 0);
        // y-hit with -y velocity
        clearTable(); setObj(7, 100, 107, 20, 20);
        runScan(100, 100, 1'b0, 1'b1, mkExp(0, 1, 100, 127, STATS), 0);
        // corner at distance^2 18: miss; the ball slot holds a box that must be ignored
        clearTable(); setObj(2, 107, 107, 20, 20); setObj(BALL_IDX, 100, 100, 20, 20);
        runScan(100, 100, 1'b0, 1'b0, mkExp(0, 0, 100, 100, 0), 0);
        // corner at distance^2 8: both axes
        clearTable(); setObj(2, 106, 106, 20, 20);
        runScan(100, 100, 1'b0, 1'b0, mkExp(1, 1, 98, 98, STATS), 0);
        // empty table, start while busy ignored, ball slot never requested
        clearTable(); setObj(BALL_IDX, 100, 100, 20, 20); ballReq = 1'b0;
        runScan(100, 100, 1'b0, 1'b0, mkExp(0, 0, 100, 100, 0), 1);
        check("ball_slot_requested", ballReq, 0);
        // two hits: higher slot position wins
        clearTable(); setObj(10, 107, 100, 20, 20); setObj(20, 106, 100, 20, 20);
        runScan(100, 100, 1'b0, 1'b0, mkExp(1, 0, 98, 100, 2 * STATS), 0);

        // reset while stalled at slot 5
        clearTable(); stall = 1'b1; stallIdx = 5;
        @(negedge clk);
        ball_x = 16'd100; ball_y = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(obj_rd_req && int'(obj_rd_idx) == 5); i++) @(negedge clk);
        check("reached_stall", (obj_rd_req && int'(obj_rd_idx) == 5) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_req", obj_rd_req, 0);
        check("abort_idx", obj_rd_idx, 0);
        check("abort_newx", new_ball_x, 0);
        check("abort_newy", new_ball_y, 0);
        check("abort_flipx", flip_x, 0);
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; forceAck = 1'b1;
        @(negedge clk);
        forceAck = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_req", obj_rd_req, 0);
        setObj(3, 107, 100, 20, 20);
        runScan(100, 100, 1'b0, 1'b0, mkExp(1, 0, 99, 100, STATS), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter MAX_OBJS, default 64, number of object-table slots scanned per frame.
REQ-002 Parameter IDX_W, default 6, slot index width; MAX_OBJS SHALL not exceed 2^IDX_W.
REQ-003 Parameter BALL_IDX, default 1, slot holding the ball; never fetched or tested.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle frame tick (nextFrame domain already synchronised to clk).
REQ-007 ball_x, ball_y  input  16 each  signed ball top-left after velocity step, sampled on start.
REQ-008 ball_w, ball_h  input  16 each  unsigned ball size; radius = ball_w>>1, sampled on start.
REQ-009 vel_x_neg, vel_y_neg  input  1 each  ball velocity sign bits, sampled on start.
REQ-010 obj_rd_req  output  1  table read request; obj_rd_idx  output  IDX_W  slot requested.
REQ-011 obj_rd_ack  input  1  read complete; obj_x, obj_y (signed), obj_w, obj_h  input  16 each, valid while ack high.
REQ-012 busy  output  1  scan in progress; done  output  1  one-cycle pulse at scan end.
REQ-013 flip_x, flip_y  output  1 each  negate ball velocity component; held until next start.
REQ-014 new_ball_x, new_ball_y  output  16 each  corrected ball position; held until next start.
REQ-015 hit_count  output  IDX_W+1  number of slots hit in last scan.

Function
REQ-016 States SHALL be IDLE, FETCH, EVAL, FINISH; IDLE on reset.
REQ-017 IDLE: start latches ball inputs, clears flip_x/flip_y/hit_count, sets new_ball_x/y to ball_x/y, sets slot=0, enters FETCH.
REQ-018 start while busy SHALL be ignored.
REQ-019 FETCH: slot==BALL_IDX SHALL advance slot without asserting obj_rd_req.
REQ-020 FETCH: otherwise obj_rd_req held high with obj_rd_idx=slot until obj_rd_ack sampled high; obj fields captured on that edge; req drops next cycle; go EVAL.
REQ-021 Captured obj_w==0 SHALL be treated as empty slot: no hit, no output change.
REQ-022 EVAL (one cycle): cx=bx+(bw>>1), cy=by+(bw>>1), r=bw>>1; dx=clamp(cx,ox,ox+ow)-cx, dy=clamp(cy,oy,oy+oh)-cy.
REQ-023 dx, dy computed at 17-bit signed; squares and sum at 35-bit unsigned; hit iff dx²+dy² < r² strictly.
REQ-024 On hit: |dx|>|dy| -> x-hit; |dx|<|dy| -> y-hit; equal -> both.
REQ-025 x-hit: flip_x=1; new_ball_x = vel_x_neg ? ox+ow : ox-bw.
REQ-026 y-hit: flip_y=1; new_ball_y = vel_y_neg ? oy+oh : oy-bh.
REQ-027 Multiple hits in one scan: flip flags OR together; position of higher slot index overrides lower.
REQ-028 After EVAL or skip: slot==MAX_OBJS-1 -> FINISH, else slot+1 -> FETCH; no wrap past MAX_OBJS-1.
REQ-029 FINISH: done high exactly one cycle, busy low next cycle, return IDLE.
REQ-030 busy SHALL be high from cycle after start through the FINISH cycle.
REQ-031 Latency with ack in first request cycle: (MAX_OBJS-1)*2 + 2 cycles start-to-done.

Reset
REQ-032 rst low SHALL immediately force IDLE, obj_rd_req=0, obj_rd_idx=0, busy=0, done=0, flip_x=0, flip_y=0, new_ball_x=0, new_ball_y=0, hit_count=0.
REQ-033 Reset mid-scan SHALL abandon the scan without a done pulse; an outstanding ack after reset SHALL be ignored.

Configuration
REQ-034 Macro COLLIDE_STATS_EN defined: hit_count increments per hit slot, saturating at 2^(IDX_W+1)-1.
REQ-035 Macro COLLIDE_STATS_EN undefined: hit_count port present, constant 0, counter logic absent.

Verification
REQ-036 Ball (100,100) w=h=8, vel +x; box (107,100,20,20) -> flip_x=1, flip_y=0, new_ball_x=99, new_ball_y=100.
REQ-037 Ball (100,100) w=h=8, vel -y; box (100,107,20,20) -> flip_y=1, flip_x=0, new_ball_y=127.
REQ-038 Box (107,107,20,20) -> dist 18, no hit; box (106,106,20,20) -> dist 8, flip_x=flip_y=1.
REQ-039 All slots empty, ack same cycle, MAX_OBJS=64 -> done exactly 128 cycles after start, no flips, slot BALL_IDX never requested.
REQ-040 rst pulsed while ack stalled at slot 5 -> outputs zero, no done; new start completes full scan.
REQ-041 Hits in slots 10 and 20 with COLLIDE_STATS_EN -> hit_count=2, position from slot 20; without macro hit_count=0.
